dmem_arbiter: RTL

DMEM_ARBITER -- requirements
Module: dmem_arbiter

---
 rtl/dmem_arbiter.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/dmem_arbiter.sv
// Two-port round-robin arbiter in front of a single-ported data memory.
// Each accepted request owns the memory for one ACCESS cycle. Completion
// (done/err/rdata) is registered and presented in the following cycle.
module dmem_arbiter #(
  parameter int MEM_WORDS = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        p0_req,
  input  logic        p1_req,
  input  logic        p0_we,
  input  logic        p1_we,
  input  logic [31:0] p0_addr,
  input  logic [31:0] p1_addr,
  input  logic [31:0] p0_wdata,
  input  logic [31:0] p1_wdata,
  output logic        p0_gnt,
  output logic        p1_gnt,
  output logic        p0_done,
  output logic        p1_done,
  output logic        p0_err,
  output logic        p1_err,
  output logic [31:0] p0_rdata,
  output logic [31:0] p1_rdata,
  output logic [31:0] mem_address,
  output logic [31:0] mem_write_data,
  output logic        mem_write,
  output logic        mem_read,
  input  logic [31:0] mem_read_data,
  output logic        busy
);

  typedef enum logic {IDLE, ACCESS} state_t;

  // One byte past the last valid word; 33 bits so large MEM_WORDS cannot wrap.
  localparam logic [32:0] ADDR_LIMIT = 33'(MEM_WORDS) * 33'd4;

  state_t      state, state_next;
  logic        last_grant;
  logic        lat_we, lat_port, lat_err;
  logic [31:0] lat_addr, lat_wdata;

  logic        accept, winner, win_we, win_err;
  logic [31:0] win_addr, win_wdata;
  logic        in_access, valid_access;

  // Pick the winner: a lone requester wins, a tie goes to the port not granted last.
  always_comb begin
    accept    = (state == IDLE) && (p0_req || p1_req);
    winner    = 1'b0;
    if (p0_req && p1_req)
      winner = ~last_grant;
    else if (p1_req)
      winner = 1'b1;
    win_we    = winner ? p1_we    : p0_we;
    win_addr  = winner ? p1_addr  : p0_addr;
    win_wdata = winner ? p1_wdata : p0_wdata;
    win_err   = (win_addr[1:0] != 2'b00) || ({1'b0, win_addr} >= ADDR_LIMIT);
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset)
      state <= IDLE;
    else
      state <= state_next;
  end

  // Next state plus all combinational outputs; reset gates the memory strobes.
  always_comb begin
    state_next     = state;
    in_access      = (state == ACCESS);
    valid_access   = in_access && !lat_err;
    busy           = in_access;
    p0_gnt         = in_access && !lat_port;
    p1_gnt         = in_access && lat_port;
    mem_address    = 32'd0;
    mem_write_data = 32'd0;
    mem_write      = 1'b0;
    mem_read       = 1'b0;
    case (state)
      IDLE:   if (accept) state_next = ACCESS;
      ACCESS: state_next = IDLE;
      default: state_next = IDLE;
    endcase
    if (in_access) begin
      mem_address = lat_addr;
      if (valid_access && lat_we)
        mem_write_data = lat_wdata;
      mem_write = valid_access && lat_we && !reset;
      mem_read  = valid_access && !lat_we && !reset;
    end
  end

  // Capture the winning request's operands and remember who was granted.
  always_ff @(posedge clk) begin
    if (reset) begin
      last_grant <= 1'b1;
      lat_we     <= 1'b0;
      lat_port   <= 1'b0;
      lat_err    <= 1'b0;
      lat_addr   <= 32'd0;
      lat_wdata  <= 32'd0;
    end else if (accept) begin
      last_grant <= winner;
      lat_we     <= win_we;
      lat_port   <= winner;
      lat_err    <= win_err;
      lat_addr   <= win_addr;
      lat_wdata  <= win_wdata;
    end
  end

  // Register completion at the edge ending ACCESS; rdata holds until the next done.
  always_ff @(posedge clk) begin
    if (reset) begin
      p0_done  <= 1'b0;
      p1_done  <= 1'b0;
      p0_err   <= 1'b0;
      p1_err   <= 1'b0;
      p0_rdata <= 32'd0;
      p1_rdata <= 32'd0;
    end else begin
      p0_done <= 1'b0;
      p1_done <= 1'b0;
      p0_err  <= 1'b0;
      p1_err  <= 1'b0;
      if (state == ACCESS) begin
        if (!lat_port) begin
          p0_done  <= 1'b1;
          p0_err   <= lat_err;
          p0_rdata <= (!lat_we && !lat_err) ? mem_read_data : 32'd0;
        end else begin
          p1_done  <= 1'b1;
          p1_err   <= lat_err;
          p1_rdata <= (!lat_we && !lat_err) ? mem_read_data : 32'd0;
        end
      end
    end
  end

endmodule
